// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared definitions for the serial frame transmitter and receiver.
//   Holds the frame-controller state encodings, the default number of
//   16-bit data words per frame, and a small helper for word indexing.
package serial_pkg;

  typedef logic [2:0] state_t;

  // Frame controller states, kept as plain constants so older blocks
  // that compare raw state codes keep working.
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RX_HI  = 3'd1;
  localparam state_t ST_RX_LO  = 3'd2;
  localparam state_t ST_CRC_HI = 3'd3;
  localparam state_t ST_CRC_LO = 3'd4;

  localparam logic [7:0] DEFAULT_N_WORD = 8'h01;

  // True when the word index points at the final data word of a frame.
  function automatic logic isLastWord(input logic [7:0] index, input logic [7:0] nWord);
    return index == (nWord - 8'd1);
  endfunction

endpackage

// File: rtl/rx_timeout_cnt.sv
// rx_timeout_cnt
//   Inter-byte gap timer for the frame receiver.
//   Ports:
//     clk       - system clock, rising edge
//     reset     - synchronous active-high reset, clears the count
//     i_clear   - load the count with zero (takes priority over enable)
//     i_enable  - advance the count by one per cycle
//     o_expired - high while the count equals TIMEOUT
module rx_timeout_cnt #(
  parameter logic [15:0] TIMEOUT = 16'd5000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [15:0] r_count;

  // The count saturates at TIMEOUT so a stalled controller never sees
  // the timer wrap around and miss the expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 16'd0;
    end else if (i_clear) begin
      r_count <= 16'd0;
    end else if (i_enable && (r_count != TIMEOUT)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_expired = (r_count == TIMEOUT);

endmodule

// File: rtl/serial_rx_ctrl.sv
// serial_rx_ctrl
//   Receive-side frame controller. Assembles byte pairs into 16-bit words,
//   feeds data bytes to an external CRC engine, checks the trailing CRC
//   and flags good frames, CRC mismatches and inter-byte timeouts.
//   Ports:
//     clk, reset   - system clock, synchronous active-high reset
//     byte_in      - received byte, valid while rx_done is high
//     rx_done      - byte strobe from the byte receiver (edge detected here)
//     crc_16       - running CRC from the CRC engine
//     crc_byte     - byte presented to the CRC engine
//     crc_en       - one-cycle CRC update strobe
//     reset_crc    - CRC engine clear
//     data_out     - assembled word {hi, lo}
//     data_select  - word index of data_out
//     data_wr      - one-cycle word write strobe
//     frame_ok     - one-cycle pulse on a good frame
//     frame_err    - one-cycle pulse on CRC mismatch or timeout
//     busy         - high whenever the controller is not idle
module serial_rx_ctrl
  import serial_pkg::*;
#(
  parameter logic [7:0]  N_WORD  = DEFAULT_N_WORD,
  parameter logic [15:0] TIMEOUT = 16'd5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        rx_done,
  input  logic [15:0] crc_16,
  output logic [7:0]  crc_byte,
  output logic        crc_en,
  output logic        reset_crc,
  output logic [15:0] data_out,
  output logic [7:0]  data_select,
  output logic        data_wr,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        busy
);

  state_t      r_state;
  logic        r_rxDonePrev;
  logic [7:0]  r_hiByte;
  logic [7:0]  r_crcHiByte;
  logic [15:0] r_crcExpected;
  logic        r_advance;
  logic [7:0]  r_crcByte;
  logic        r_crcEn;
  logic        r_resetCrc;
  logic [15:0] r_dataOut;
  logic [7:0]  r_dataSelect;
  logic        r_dataWr;
  logic        r_frameOk;
  logic        r_frameErr;

  logic w_byteEvent;
  logic w_timerClear;
  logic w_timerEnable;
  logic w_timerExpired;

  // A held rx_done counts once: only its rising edge is a byte event.
  assign w_byteEvent   = rx_done & ~r_rxDonePrev;
  assign w_timerClear  = w_byteEvent | (r_state == ST_IDLE);
  assign w_timerEnable = (r_state != ST_IDLE);

  rx_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_timerClear),
    .i_enable (w_timerEnable),
    .o_expired(w_timerExpired)
  );

  // Frame state machine. Strobes default low every cycle. The word index
  // is advanced one cycle after the lo byte so data_select still names the
  // word being written while data_wr is high; rx_done must fall before the
  // next event, so the deferred increment always lands first.
  // r_rxDonePrev resets high so an rx_done already high at reset release
  // is ignored until it drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_rxDonePrev  <= 1'b1;
      r_hiByte      <= 8'd0;
      r_crcHiByte   <= 8'd0;
      r_crcExpected <= 16'd0;
      r_advance     <= 1'b0;
      r_crcByte     <= 8'd0;
      r_crcEn       <= 1'b0;
      r_resetCrc    <= 1'b1;
      r_dataOut     <= 16'd0;
      r_dataSelect  <= 8'd0;
      r_dataWr      <= 1'b0;
      r_frameOk     <= 1'b0;
      r_frameErr    <= 1'b0;
    end else begin
      r_rxDonePrev <= rx_done;
      r_crcEn      <= 1'b0;
      r_dataWr     <= 1'b0;
      r_frameOk    <= 1'b0;
      r_frameErr   <= 1'b0;
      r_advance    <= 1'b0;

      if (r_advance) begin
        r_dataSelect <= r_dataSelect + 8'd1;
      end

      if ((r_state != ST_IDLE) && !w_byteEvent && w_timerExpired) begin
        // Gap too long: abandon the frame.
        r_frameErr   <= 1'b1;
        r_resetCrc   <= 1'b1;
        r_dataSelect <= 8'd0;
        r_state      <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_resetCrc   <= 1'b1;
            r_dataSelect <= 8'd0;
            if (w_byteEvent) begin
              r_crcByte  <= byte_in;
              r_crcEn    <= 1'b1;
              r_resetCrc <= 1'b0;
              r_hiByte   <= byte_in;
              r_state    <= ST_RX_LO;
            end
          end
          ST_RX_HI: begin
            if (w_byteEvent) begin
              r_crcByte  <= byte_in;
              r_crcEn    <= 1'b1;
              r_resetCrc <= 1'b0;
              r_hiByte   <= byte_in;
              r_state    <= ST_RX_LO;
            end
          end
          ST_RX_LO: begin
            if (w_byteEvent) begin
              r_crcByte  <= byte_in;
              r_crcEn    <= 1'b1;
              r_resetCrc <= 1'b0;
              r_dataOut  <= {r_hiByte, byte_in};
              r_dataWr   <= 1'b1;
              if (isLastWord(r_dataSelect, N_WORD)) begin
                r_state <= ST_CRC_HI;
              end else begin
                r_advance <= 1'b1;
                r_state   <= ST_RX_HI;
              end
            end
          end
          ST_CRC_HI: begin
            if (w_byteEvent) begin
              r_crcExpected <= crc_16;
              r_crcHiByte   <= byte_in;
              r_state       <= ST_CRC_LO;
            end
          end
          ST_CRC_LO: begin
            if (w_byteEvent) begin
              if ({r_crcHiByte, byte_in} == r_crcExpected) begin
                r_frameOk <= 1'b1;
              end else begin
                r_frameErr <= 1'b1;
              end
              r_resetCrc   <= 1'b1;
              r_dataSelect <= 8'd0;
              r_state      <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign crc_byte    = r_crcByte;
  assign crc_en      = r_crcEn;
  assign reset_crc   = r_resetCrc;
  assign data_out    = r_dataOut;
  assign data_select = r_dataSelect;
  assign data_wr     = r_dataWr;
  assign frame_ok    = r_frameOk;
  assign frame_err   = r_frameErr;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: doc/serial_rx_ctrl.md
SERIAL_RX_CTRL -- requirements
Module: serial_rx_ctrl

Interface
REQ-001 SHALL have parameter N_WORD, 8 bits, default 8'h01, meaning number of 16-bit data words per frame (legal 1..255).
REQ-002 SHALL have parameter TIMEOUT, 16 bits, default 16'd5000, meaning the inter-byte gap limit in clk cycles.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port byte_in, input, 8, received byte, valid while rx_done high.
REQ-006 SHALL have port rx_done, input, 1, byte-received strobe from the byte receiver.
REQ-007 SHALL have port crc_16, input, 16, running CRC from the external CRC engine.
REQ-008 SHALL have port crc_byte, output, 8, byte presented to the CRC engine.
REQ-009 SHALL have port crc_en, output, 1, one-cycle CRC update strobe.
REQ-010 SHALL have port reset_crc, output, 1, CRC engine clear.
REQ-011 SHALL have port data_out, output, 16, assembled word {hi,lo}.
REQ-012 SHALL have port data_select, output, 8, word index of data_out.
REQ-013 SHALL have port data_wr, output, 1, one-cycle word write strobe.
REQ-014 SHALL have port frame_ok, output, 1, one-cycle pulse on a good frame.
REQ-015 SHALL have port frame_err, output, 1, one-cycle pulse on CRC mismatch or timeout.
REQ-016 SHALL have port busy, output, 1, high while in any state other than IDLE.

Function
REQ-017 SHALL define a byte event as rx_done=1 while the previous-cycle registered rx_done=0; a held rx_done yields one event.
REQ-018 SHALL implement states IDLE, RX_HI, RX_LO, CRC_HI and CRC_LO.
REQ-019 SHALL, in IDLE, hold reset_crc=1 and data_select=0, and treat the next byte event as the first data hi byte.
REQ-020 SHALL, on each data byte event, register crc_byte=byte_in, crc_en=1 for one cycle and reset_crc=0 on that edge.
REQ-021 SHALL, on the hi-byte event, latch byte_in as the hi byte and go to RX_LO.
REQ-022 SHALL, on the lo-byte event, register data_out={hi,byte_in}, data_wr=1 for one cycle, and hold data_select at the current index.
REQ-023 SHALL, after a lo-byte event, increment data_select and go to RX_HI; if data_select==N_WORD-1, it SHALL instead go to CRC_HI.
REQ-024 SHALL not assert crc_en for CRC bytes.
REQ-025 SHALL, on the CRC_HI event, latch crc_16 as the expected value and the byte as the received CRC hi byte.
REQ-026 SHALL, on the CRC_LO event, compare {crc_hi,byte_in} with the expected value.
REQ-027 SHALL, after the compare, pulse frame_ok on a match or frame_err on a mismatch, then return to IDLE with reset_crc=1.
REQ-028 SHALL load the timeout counter with 0 on every byte event and increment it in non-IDLE states.
REQ-029 SHALL, at count==TIMEOUT, pulse frame_err, assert reset_crc, clear data_select and go to IDLE.
REQ-030 SHALL give a byte event priority over timeout when both occur in the same cycle.
REQ-031 SHALL have a latency of exactly one clk from the event-sampling edge to data_wr, crc_en, frame_ok and frame_err.

Reset
REQ-032 SHALL, on reset, force state=IDLE, reset_crc=1, crc_en=0, data_wr=0, frame_ok=0, frame_err=0, busy=0, data_select=0, data_out=0, crc_byte=0 and timeout count=0.
REQ-033 SHALL abort any frame on reset mid-frame with no frame_err pulse, and SHALL ignore a rx_done high at reset release until it falls.

Structure
REQ-034 SHALL take its state encodings and the default N_WORD from the shared package serial_pkg, which is also used by the transmitter.
REQ-035 SHALL implement the inter-byte timer as one sub-module, rx_timeout_cnt (clear, enable, expired).

Verification
REQ-036 SHALL cover: N_WORD=1, bytes 12,34, then CRC bytes equal to crc_16 -> data_wr with data_out=16'h1234, data_select=0, then frame_ok.
REQ-037 SHALL cover: N_WORD=2, bytes AB,CD,01,02 and a good CRC -> writes of ABCD@0 and 0102@1, then frame_ok.
REQ-038 SHALL cover: a good frame with the CRC lo byte XOR 8'h01 -> frame_err, no frame_ok, reset_crc=1 after.
REQ-039 SHALL cover: TIMEOUT=16, one byte then silence -> frame_err after 16 cycles, then IDLE and busy=0.
REQ-040 SHALL cover: rx_done held high for 10 cycles -> exactly one crc_en.
REQ-041 SHALL cover: reset after 3 bytes -> no frame_err, and the following full frame gives frame_ok.
